acc_requant_drain: RTL and testbench

- Reads finished accumulators from a mac_unit, requantizes each INT32 sum to INT8 and hands it downstream over a valid/ready stream.
- After capturing a result it pulses the MAC's clear line, so the MAC can start the next dot product.
- Sits between the MAC array outputs and the output activation buffer.
- Processes one result at a time through a fixed 4-state FSM.

---
 rtl/acc_requant_drain.sv | 166 ++++++++++++++++
 tb/tb_acc_requant_drain.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_requant_drain.sv
// Drains finished MAC accumulators one at a time, requantizes INT32 -> INT8
// (scale, round-half-up shift, zero point, saturate) and streams the result out.
module acc_requant_drain #(
  parameter int ACC_WIDTH    = 32,
  parameter int DATA_WIDTH   = 8,
  parameter int SCALE_WIDTH  = 16,
  parameter int SHIFT_WIDTH  = 5,
  parameter int SATCNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ACC_WIDTH-1:0]    acc_in,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  output logic                    clear_acc_o,
  input  logic [SCALE_WIDTH-1:0]  cfg_scale,
  input  logic [SHIFT_WIDTH-1:0]  cfg_shift,
  input  logic [DATA_WIDTH-1:0]   cfg_zero_point,
  output logic [DATA_WIDTH-1:0]   q_out,
  output logic                    q_valid,
  input  logic                    q_ready,
  output logic [SATCNT_WIDTH-1:0] sat_count,
  input  logic                    sat_clear
);

  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH;
  localparam int RND_W  = PROD_W + 1;
  localparam int V_W    = RND_W + 1;

  localparam logic [RND_W-1:0] RND_ONE = {{(RND_W-1){1'b0}}, 1'b1};
  localparam logic signed [V_W-1:0] Q_MAX =
    {{(V_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [V_W-1:0] Q_MIN =
    {{(V_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [SATCNT_WIDTH-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RQ   = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [ACC_WIDTH-1:0]   acc_r;
  logic signed [SCALE_WIDTH-1:0] scale_r;
  logic [SHIFT_WIDTH-1:0]        shift_r;
  logic signed [DATA_WIDTH-1:0]  zp_r;
  logic signed [PROD_W-1:0]      prod_r;
  logic signed [PROD_W-1:0]      prod_full;

  logic signed [RND_W-1:0]       prod_ext;
  logic signed [RND_W-1:0]       rnd_add;
  logic signed [RND_W-1:0]       rnd_sum;
  logic signed [RND_W-1:0]       shifted;
  logic signed [V_W-1:0]         v;
  logic [DATA_WIDTH-1:0]         q_sat;
  logic                          sat_hit;
  logic                          capture;

  // Both streams use plain valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; the producer holds its data stable
  // while valid is high and ready is low.
  assign capture = acc_valid && acc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    acc_ready   = 1'b0;
    clear_acc_o = 1'b0;
    q_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        acc_ready = 1'b1;
        if (acc_valid) state_next = S_MUL;
      end
      S_MUL: begin
        clear_acc_o = 1'b1;
        state_next  = S_RQ;
      end
      S_RQ: begin
        state_next = S_OUT;
      end
      S_OUT: begin
        q_valid = 1'b1;
        if (q_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Config is latched with the accumulator so mid-flight cfg changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      scale_r <= '0;
      shift_r <= '0;
      zp_r    <= '0;
    end else if (capture) begin
      acc_r   <= acc_in;
      scale_r <= cfg_scale;
      shift_r <= cfg_shift;
      zp_r    <= cfg_zero_point;
    end
  end

  assign prod_full = $signed({{SCALE_WIDTH{acc_r[ACC_WIDTH-1]}}, acc_r}) *
                     $signed({{ACC_WIDTH{scale_r[SCALE_WIDTH-1]}}, scale_r});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r <= '0;
    end else if (state == S_MUL) begin
      prod_r <= prod_full;
    end
  end

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    prod_ext = {prod_r[PROD_W-1], prod_r};
    rnd_add  = '0;
    if (shift_r != '0) rnd_add = RND_ONE << (shift_r - SHIFT_WIDTH'(1));
    rnd_sum  = prod_ext + rnd_add;
    shifted  = rnd_sum >>> shift_r;
    v        = {shifted[RND_W-1], shifted} +
               {{(V_W-DATA_WIDTH){zp_r[DATA_WIDTH-1]}}, zp_r};
    sat_hit  = 1'b0;
    q_sat    = v[DATA_WIDTH-1:0];
    if (v > Q_MAX) begin
      q_sat   = Q_MAX[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (v < Q_MIN) begin
      q_sat   = Q_MIN[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out <= '0;
    end else if (state == S_RQ) begin
      q_out <= q_sat;
    end
  end

  // sat_clear takes priority over a saturation event in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (state == S_RQ && sat_hit && sat_count != SAT_MAX) begin
      sat_count <= sat_count + SATCNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_acc_requant_drain.sv
// Self-checking bench for acc_requant_drain: directed cases from the test plan
// plus randomized traffic, checked every cycle against a transaction-level model.
module tb_acc_requant_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] acc_in = '0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic        clear_acc_o;
  logic [15:0] cfg_scale = '0;
  logic [4:0]  cfg_shift = '0;
  logic [7:0]  cfg_zero_point = '0;
  logic [7:0]  q_out;
  logic        q_valid;
  logic        q_ready = 1'b1;
  logic [15:0] sat_count;
  logic        sat_clear = 1'b0;

  acc_requant_drain dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .acc_in         (acc_in),
    .acc_valid      (acc_valid),
    .acc_ready      (acc_ready),
    .clear_acc_o    (clear_acc_o),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .cfg_zero_point (cfg_zero_point),
    .q_out          (q_out),
    .q_valid        (q_valid),
    .q_ready        (q_ready),
    .sat_count      (sat_count),
    .sat_clear      (sat_clear)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int qr_mode  = 1;   // 0: hold low, 1: hold high, 2: random

  always begin
    @(posedge clk);
    #1;
    case (qr_mode)
      0:       q_ready = 1'b0;
      1:       q_ready = 1'b1;
      default: q_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint requant_raw(input longint a, input longint s,
                                         input int sh, input longint z);
    longint p;
    p = a * s;
    if (sh > 0) p = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    return p + z;
  endfunction

  function automatic longint clamp8(input longint x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // age = cycles since the item was accepted (0 = nothing in flight);
  // at age 3 the item waits for the downstream handshake.
  int              age = 0;
  longint          cur_val = 0;
  bit              cur_sat = 1'b0;
  longint          m_q_out = 0;
  longint          m_sat = 0;
  logic [7:0]      exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    longint raw;
    if (!rst_n) begin
      age     = 0;
      m_q_out = 0;
      m_sat   = 0;
      exp_q.delete();
    end else begin
      if (sat_clear) m_sat = 0;
      else if (age == 2 && cur_sat && m_sat < 65535) m_sat = m_sat + 1;
      case (age)
        0: if (acc_valid) begin
          raw     = requant_raw(longint'($signed(acc_in)), longint'($signed(cfg_scale)),
                                int'(cfg_shift), longint'($signed(cfg_zero_point)));
          cur_val = clamp8(raw);
          cur_sat = (raw != cur_val);
          age     = 1;
        end
        1: age = 2;
        2: begin
          m_q_out = cur_val;
          exp_q.push_back(8'(cur_val));
          age = 3;
        end
        default: if (q_ready) age = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (chk_en) begin
      check("acc_ready", acc_ready, age == 0);
      check("clear_acc_o", clear_acc_o, age == 1);
      check("q_valid", q_valid, age == 3);
      check("q_out", $signed(q_out), m_q_out);
      check("sat_count", sat_count, m_sat);
      if (q_valid && q_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("xfer_data", $signed(q_out), $signed(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input longint a, input longint s, input longint sh, input longint z);
    int n = 0;
    @(posedge clk);
    #2;
    acc_in = 32'(a);
    cfg_scale = 16'(s);
    cfg_shift = 5'(sh);
    cfg_zero_point = 8'(z);
    acc_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (acc_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #2;
    acc_valid = 1'b0;
    acc_in = $urandom;
  endtask

  // Waits for q_valid; returns negedges waited and clear pulses seen meanwhile.
  task automatic wait_out(input string name, input longint exp,
                          output int lat, output int clr);
    lat = 0;
    clr = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (clear_acc_o) clr++;
      if (q_valid) break;
      if (lat >= 50) begin
        check({name, "_timeout"}, 0, 1);
        return;
      end
    end
    check(name, $signed(q_out), exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, clr, n;
    longint a, s;

    // model pins: hand-computed values
    check("pin_basic", requant_raw(100, 16384, 15, 0), 50);
    check("pin_rnd_p3", requant_raw(3, 1, 1, 0), 2);
    check("pin_rnd_m3", requant_raw(-3, 1, 1, 0), -1);
    check("pin_rnd_m4", requant_raw(-4, 1, 1, 0), -2);
    check("pin_zp", requant_raw(100, 16384, 15, -10), 40);
    check("pin_sat_lo", clamp8(requant_raw(-100000, 1, 0, 0)), -128);
    check("pin_sat_hi", clamp8(requant_raw(1000, 1, 0, 0)), 127);

    repeat (3) @(posedge clk);
    #2;
    check("reset_acc_ready", acc_ready, 1);
    check("reset_q_valid", q_valid, 0);
    check("reset_clear", clear_acc_o, 0);
    check("reset_q_out", q_out, 0);
    check("reset_sat", sat_count, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // basic scaling, latency and clear pulse
    send(100, 16384, 15, 0);
    wait_out("basic", 50, lat, clr);
    check("basic_latency", lat, 3);
    check("basic_clear_cycles", clr, 1);
    check("basic_sat", sat_count, 0);

    send(3, 1, 1, 0);     wait_out("round_p3", 2, lat, clr);
    send(-3, 1, 1, 0);    wait_out("round_m3", -1, lat, clr);
    send(-4, 1, 1, 0);    wait_out("round_m4", -2, lat, clr);
    send(100, 16384, 15, -10); wait_out("zero_point", 40, lat, clr);
    send(-100000, 1, 0, 0);    wait_out("sat_low", -128, lat, clr);
    check("sat_low_count", sat_count, 1);
    send(1000, 1, 0, 0);       wait_out("sat_high", 127, lat, clr);
    check("sat_high_count", sat_count, 2);

    // backpressure with an ignored acc_valid pulse
    @(posedge clk);
    #2;
    qr_mode = 0;
    send(100, 16384, 15, 5);
    wait_out("stall_out", 55, lat, clr);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      acc_valid = (i == 2);
      acc_in = 77;
      @(negedge clk);
      check("stall_valid", q_valid, 1);
      check("stall_q_out", $signed(q_out), 55);
      check("stall_acc_ready", acc_ready, 0);
    end
    @(posedge clk);
    #2;
    acc_valid = 1'b0;
    qr_mode = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q_valid && n < 10);
    check("release_acc_ready", acc_ready, 1);
    check("release_q_out_kept", $signed(q_out), 55);

    // config isolation
    send(100, 16384, 15, 0);
    cfg_scale = 16'd1;
    wait_out("cfg_isolation", 50, lat, clr);

    // reset during RQ drops the item
    send(1000, 1, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_acc_ready", acc_ready, 1);
    check("post_reset_q_valid", q_valid, 0);
    check("post_reset_sat", sat_count, 0);
    repeat (4) @(negedge clk);
    check("dropped_item_q_valid", q_valid, 0);

    // three saturations, then sat_clear against a fourth
    for (int i = 0; i < 3; i++) begin
      send(1000, 1, 0, 0);
      wait_out("sat3_item", 127, lat, clr);
    end
    check("sat3_count", sat_count, 3);
    send(-5000, 1, 0, 0);
    @(posedge clk);
    #2;
    sat_clear = 1'b1;
    @(posedge clk);
    #2;
    sat_clear = 1'b0;
    wait_out("sat_clear_item", -128, lat, clr);
    check("sat_clear_wins", sat_count, 0);

    // randomized traffic
    qr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 1) != 0) a = longint'($signed($urandom));
      else a = longint'($urandom_range(0, 4000)) - 2000;
      s = longint'($urandom_range(0, 65535)) - 32768;
      send(a, s, $urandom_range(0, 31), longint'($urandom_range(0, 255)) - 128);
      if ($urandom_range(0, 15) == 0) begin
        @(posedge clk);
        #2;
        sat_clear = 1'b1;
        @(posedge clk);
        #2;
        sat_clear = 1'b0;
      end
    end
    qr_mode = 1;
    n = 0;
    while ((age != 0 || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500us;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
